// File: rtl/mult_share_arbiter_if.sv
// Requester/result/multiplier bundle for mult_share_arbiter.
// The master side is the requesters plus the external multiplier; the slave side is the arbiter.
interface mult_share_arbiter_if #(
   parameter int SIZE  = 8,
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ-1:0]          req_ready;
   logic [N_REQ*SIZE-1:0]     req_a;
   logic [N_REQ*SIZE-1:0]     req_b;
   logic [SIZE-1:0]           mult_a;
   logic [SIZE-1:0]           mult_b;
   logic [2*SIZE-1:0]         mult_p;
   logic [N_REQ-1:0]          res_valid;
   logic [N_REQ-1:0]          res_ready;
   logic [N_REQ*2*SIZE-1:0]   res_p;

   modport master (
      output req_valid, req_a, req_b, res_ready, mult_p,
      input  req_ready, mult_a, mult_b, res_valid, res_p
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready, mult_p,
      output req_ready, mult_a, mult_b, res_valid, res_p
   );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one external signed multiplier among N_REQ requesters, one grant per cycle.
// Define MULT_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mult_share_arbiter #(
   parameter int SIZE     = 8,
   parameter int N_REQ    = 4,
   parameter int MULT_LAT = 1
)(
   input  logic               clk,
   input  logic               reset,
   mult_share_arbiter_if.slave bus
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]              r_busy;
   logic [N_REQ-1:0]              r_res_valid;
   logic [N_REQ-1:0][2*SIZE-1:0]  r_res_p;
   logic [MULT_LAT:1]             r_tag_vld;
   logic [MULT_LAT:1][IDW-1:0]    r_tag_id;

   logic [N_REQ-1:0]              w_elig;
   logic [N_REQ-1:0]              w_gnt;
   logic [N_REQ-1:0]              w_res_hs;
   logic [IDW-1:0]                w_gnt_id;
   logic                          w_gnt_vld;
   logic                          w_out_vld;
   logic [IDW-1:0]                w_out_id;

   // A requester with an un-consumed result stays ineligible, so a slot is never overwritten.
   assign w_elig   = bus.req_valid & ~r_busy & {N_REQ{~reset}};
   assign w_res_hs = r_res_valid & bus.res_ready;

`ifdef MULT_SHARE_FIXED_PRIO_EN
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      for (int i = N_REQ-1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] r_last_grant;
   logic [IDW-1:0] w_idx;

   // Scan from farthest to nearest so the index right after last_grant wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      w_idx     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_idx = IDW'((int'(r_last_grant) + k) % N_REQ);
         if (w_elig[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)          r_last_grant <= IDW'(N_REQ-1);
      else if (w_gnt_vld) r_last_grant <= w_gnt_id;
   end
`endif

   assign w_gnt         = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;
   assign bus.req_ready = w_gnt;
   assign bus.mult_a    = w_gnt_vld ? bus.req_a[w_gnt_id*SIZE +: SIZE] : '0;
   assign bus.mult_b    = w_gnt_vld ? bus.req_b[w_gnt_id*SIZE +: SIZE] : '0;

   // Tag travels alongside the multiplier pipeline; stage MULT_LAT lines up with mult_p.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_vld <= '0;
         r_tag_id  <= '0;
      end else begin
         r_tag_vld[1] <= w_gnt_vld;
         r_tag_id[1]  <= w_gnt_id;
         for (int s = 2; s <= MULT_LAT; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_id[s]  <= r_tag_id[s-1];
         end
      end
   end

   assign w_out_vld = r_tag_vld[MULT_LAT];
   assign w_out_id  = r_tag_id[MULT_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy      <= '0;
         r_res_valid <= '0;
         r_res_p     <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i])         r_busy[i] <= 1'b1;
            else if (w_res_hs[i]) r_busy[i] <= 1'b0;

            if (w_out_vld && (w_out_id == IDW'(i))) begin
               r_res_valid[i] <= 1'b1;
               r_res_p[i]     <= bus.mult_p;
            end else if (w_res_hs[i]) begin
               r_res_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.res_valid = r_res_valid;
   assign bus.res_p     = r_res_p;

   a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
      w_out_vld |-> !r_res_valid[w_out_id]);
   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(w_gnt) && ((w_gnt & r_busy) == '0));
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed scoreboard bench for mult_share_arbiter with an ideal 1-cycle multiplier.
// Stimulus pushes expected grants/results; negedge monitors pop and compare.
module tb_mult_share_arbiter;
   localparam int SIZE = 8;
   localparam int N    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mult_share_arbiter_if #(.SIZE(SIZE), .N_REQ(N)) bus ();

   mult_share_arbiter #(.SIZE(SIZE), .N_REQ(N), .MULT_LAT(1)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   logic       tb_valid [N];
   logic [7:0] tb_a [N];
   logic [7:0] tb_b [N];
   logic [3:0] tb_rr;
   logic [15:0] mp;

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign bus.req_valid[g]     = tb_valid[g];
      assign bus.req_a[g*8 +: 8]  = tb_a[g];
      assign bus.req_b[g*8 +: 8]  = tb_b[g];
   end
   assign bus.res_ready = tb_rr;
   assign bus.mult_p    = mp;

   // Ideal multiplier: product appears one cycle after operands.
   always @(posedge clk) begin
      if (rst) mp <= '0;
      else     mp <= $signed({{8{bus.mult_a[7]}}, bus.mult_a}) * $signed({{8{bus.mult_b[7]}}, bus.mult_b});
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   logic [15:0] exp_q [N][$];
   int          exp_gnt[$];
   int          exp_rid[$];
   int          gnt_cyc [N];
   int          res_hs_cyc [N];

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one operand pair and hold it until granted (bounded).
   task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit want_res);
      bit got;
      got = 1'b0;
      tb_a[i] = a;
      tb_b[i] = b;
      tb_valid[i] = 1'b1;
      if (want_res) exp_q[i].push_back(exp);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.req_ready[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk(1'b0, "grant_timeout", 32'(i), 32'(i));
      @(posedge clk);
      #1;
      tb_valid[i] = 1'b0;
   endtask

   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int k = 0; k < 60 && !empty; k++) begin
         tick();
         empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                 (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
      end
      tick();
      tick();
      chk(empty && exp_gnt.size() == 0 && exp_rid.size() == 0, "drain",
          32'(exp_gnt.size() + exp_rid.size()), 32'd0);
   endtask

   // Result monitor: values, order, latency, hold-while-stalled, clear-after-consume.
   logic [N-1:0] prev_rv = '0;
   logic [N-1:0] prev_hs = '0;
   logic [15:0]  prev_p [N];

   always @(negedge clk) begin
      logic        rv, hs;
      logic [15:0] rp, e;
      int          eid;
      for (int i = 0; i < N; i++) begin
         rv = bus.res_valid[i];
         rp = bus.res_p[i*16 +: 16];
         hs = rv & tb_rr[i];
         if (!rst && prev_rv[i] && !prev_hs[i])
            chk(rv && rp == prev_p[i], "res_hold", {15'd0, rv, rp}, {16'd1, prev_p[i]});
         if (!rst && prev_hs[i])
            chk(!rv, "res_clear", 32'(rv), 32'd0);
         if (!rst && rv && !prev_rv[i])
            chk(cyc == gnt_cyc[i] + 2, "res_latency", 32'(cyc), 32'(gnt_cyc[i] + 2));
         if (hs) begin
            res_hs_cyc[i] = cyc;
            if (exp_q[i].size() == 0) begin
               chk(1'b0, "unexpected_result", 32'(i), 32'hFFFF_FFFF);
            end else begin
               e = exp_q[i].pop_front();
               chk(rp == e, "res_p", 32'(rp), 32'(e));
            end
            if (exp_rid.size() == 0) begin
               chk(1'b0, "result_order_extra", 32'(i), 32'hFFFF_FFFF);
            end else begin
               eid = exp_rid.pop_front();
               chk(i == eid, "result_order", 32'(i), 32'(eid));
            end
         end
         prev_rv[i] = rv;
         prev_hs[i] = hs;
         prev_p[i]  = rp;
      end
   end

   // Grant monitor: one-hot, operand mux, grant order.
   always @(negedge clk) begin
      int id, eg;
      if (|bus.req_ready) begin
         chk($onehot(bus.req_ready), "gnt_onehot", 32'(bus.req_ready), 32'd0);
         id = 0;
         for (int i = 0; i < N; i++) if (bus.req_ready[i]) id = i;
         gnt_cyc[id] = cyc;
         chk(bus.mult_a == tb_a[id] && bus.mult_b == tb_b[id], "mult_operands",
             {16'd0, bus.mult_a, bus.mult_b}, {16'd0, tb_a[id], tb_b[id]});
         if (exp_gnt.size() == 0) begin
            chk(1'b0, "unexpected_grant", 32'(id), 32'hFFFF_FFFF);
         end else begin
            eg = exp_gnt.pop_front();
            chk(id == eg, "grant_order", 32'(id), 32'(eg));
         end
      end else if (!rst) begin
         chk(bus.mult_a == 8'd0 && bus.mult_b == 8'd0, "idle_operands",
             {16'd0, bus.mult_a, bus.mult_b}, 32'd0);
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         tb_valid[i]   = 1'b1;
         tb_a[i]       = 8'h11;
         tb_b[i]       = 8'h22;
         gnt_cyc[i]    = 0;
         res_hs_cyc[i] = 0;
      end
      tb_rr = 4'hF;

      // Reset state: valid offered but nothing granted or produced.
      repeat (3) tick();
      @(negedge clk);
      chk(bus.req_ready == 4'h0, "rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk(bus.res_valid == 4'h0, "rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk(bus.res_p == '0, "rst_res_p", bus.res_p[31:0], 32'd0);
      chk(bus.mult_a == 8'd0, "rst_mult_a", 32'(bus.mult_a), 32'd0);
      for (int i = 0; i < N; i++) tb_valid[i] = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // All four requesters at once: 0,1,2,3.
      exp_gnt = '{0, 1, 2, 3};
      exp_rid = '{0, 1, 2, 3};
      fork
         issue(0, 8'h02, 8'h03, 16'h0006, 1'b1);
         issue(1, 8'hFE, 8'h07, 16'hFFF2, 1'b1);
         issue(2, 8'h0A, 8'h0A, 16'h0064, 1'b1);
         issue(3, 8'hFF, 8'hFF, 16'h0001, 1'b1);
      join
      drain();

      // Single request: -3 * 5.
      exp_gnt = '{0};
      exp_rid = '{0};
      issue(0, 8'hFD, 8'h05, 16'hFFF1, 1'b1);
      drain();

      // Last grant was 0: round-robin prefers 1, fixed priority prefers 0.
`ifdef MULT_SHARE_FIXED_PRIO_EN
      exp_gnt = '{0, 1};
      exp_rid = '{0, 1};
`else
      exp_gnt = '{1, 0};
      exp_rid = '{1, 0};
`endif
      fork
         issue(0, 8'h04, 8'h05, 16'h0014, 1'b1);
         issue(1, 8'h06, 8'hFB, 16'hFFE2, 1'b1);
      join
      drain();

      // Backpressure on requester 1 with valid held for a second operation.
      tb_rr[1] = 1'b0;
      exp_gnt = '{1, 1};
      exp_rid = '{1, 1};
      fork
         begin
            issue(1, 8'h07, 8'h09, 16'h003F, 1'b1);
            issue(1, 8'hF9, 8'h09, 16'hFFC1, 1'b1);
         end
         begin
            repeat (10) tick();
            chk(bus.res_valid[1] == 1'b1, "bp_res_valid", 32'(bus.res_valid[1]), 32'd1);
            chk(bus.res_p[31:16] == 16'h003F, "bp_res_p", 32'(bus.res_p[31:16]), 32'h003F);
            tb_rr[1] = 1'b1;
         end
      join
      chk(gnt_cyc[1] == res_hs_cyc[1] + 1, "bp_regrant_cycle", 32'(gnt_cyc[1]), 32'(res_hs_cyc[1] + 1));
      drain();

      // Extremes.
      exp_gnt = '{2, 3, 0};
      exp_rid = '{2, 3, 0};
      issue(2, 8'h80, 8'h80, 16'h4000, 1'b1);
      issue(3, 8'h7F, 8'h80, 16'hC080, 1'b1);
      issue(0, 8'h00, 8'hFF, 16'h0000, 1'b1);
      drain();

      // Reset the cycle after a grant: the in-flight product must vanish.
      exp_gnt = '{1};
      issue(1, 8'h05, 8'h05, 16'h0019, 1'b0);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      exp_gnt = '{0, 2};
      exp_rid = '{0, 2};
      fork
         issue(0, 8'h03, 8'h03, 16'h0009, 1'b1);
         issue(2, 8'h02, 8'hFD, 16'hFFFA, 1'b1);
      join
      drain();

      // Two requesters always valid: 0,2,0,2,0,2.
      exp_gnt = '{0, 2, 0, 2, 0, 2};
      exp_rid = '{0, 2, 0, 2, 0, 2};
      fork
         begin
            issue(0, 8'h01, 8'h03, 16'h0003, 1'b1);
            issue(0, 8'h02, 8'h03, 16'h0006, 1'b1);
            issue(0, 8'h03, 8'h03, 16'h0009, 1'b1);
         end
         begin
            issue(2, 8'hFF, 8'h04, 16'hFFFC, 1'b1);
            issue(2, 8'hFE, 8'h04, 16'hFFF8, 1'b1);
            issue(2, 8'hFD, 8'h04, 16'hFFF4, 1'b1);
         end
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
- REQ-001 SHALL have parameter SIZE, default 8: operand width in bits, signed two's complement.
- REQ-002 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
- REQ-003 SHALL have parameter MULT_LAT, default 1: cycles from operands driven on mult_a/mult_b to product valid on mult_p, 1..4.
- REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
- REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port req_valid, input, N_REQ: per-requester operand offer.
- REQ-007 SHALL have port req_ready, output, N_REQ: per-requester grant; handshake = req_valid[i] & req_ready[i].
- REQ-008 SHALL have port req_a, input, N_REQ*SIZE: operand A, requester i at bits [i*SIZE +: SIZE].
- REQ-009 SHALL have port req_b, input, N_REQ*SIZE: operand B, same packing as req_a.
- REQ-010 SHALL have port mult_a, output, SIZE: operand A to the shared external signed multiplier.
- REQ-011 SHALL have port mult_b, output, SIZE: operand B to the shared multiplier.
- REQ-012 SHALL have port mult_p, input, 2*SIZE: signed product returned by the multiplier.
- REQ-013 SHALL have port res_valid, output, N_REQ: per-requester result available.
- REQ-014 SHALL have port res_ready, input, N_REQ: per-requester result consumed; handshake = res_valid[i] & res_ready[i].
- REQ-015 SHALL have port res_p, output, N_REQ*2*SIZE: held product, requester i at bits [i*2*SIZE +: 2*SIZE].

Function
- REQ-016 SHALL keep per-requester busy flag: set on request handshake, cleared on result handshake; eligible[i] = req_valid[i] & ~busy[i].
- REQ-017 SHALL grant at most one eligible requester per cycle; req_ready is combinational, one-hot or zero, and never asserted to a busy requester.
- REQ-018 SHALL arbitrate round-robin: priority starts at index (last_grant+1) mod N_REQ; last_grant updates only on a grant.
- REQ-019 SHALL drive mult_a/mult_b combinationally from the granted requester's operands and drive zero when no grant.
- REQ-020 SHALL carry a tag {valid, id} through a MULT_LAT-deep shift register aligned with the multiplier pipeline; no grant inserts valid=0.
- REQ-021 SHALL, when the tag output is valid, register mult_p into res_p[id] and set res_valid[id]; res_valid first high MULT_LAT+1 cycles after the request-handshake cycle.
- REQ-022 SHALL hold res_p[i] and res_valid[i] stable until the result handshake; res_valid[i] then clears next cycle.
- REQ-023 SHALL treat a result handshake and a new req_valid in the same cycle as follows: busy is still set, so no grant that cycle; earliest re-grant is next cycle.
- REQ-024 SHALL sustain one grant per cycle across distinct requesters; per requester, at most one transaction is outstanding.
- REQ-025 SHALL never overwrite an un-consumed result; this is guaranteed by REQ-016, and an assertion SHALL flag any violation.

Reset
- REQ-026 SHALL, while reset is high, clear busy, tag pipeline, res_valid and res_p to 0, set last_grant to N_REQ-1 so requester 0 has first priority, and hold req_ready at 0.
- REQ-027 SHALL discard products in flight when reset is asserted mid-operation; no res_valid results from pre-reset grants.

Configuration
- REQ-028 SHALL support macro MULT_SHARE_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest eligible index wins) and the last_grant state is removed; when undefined, round-robin per REQ-018 applies.

Verification (SIZE=8, N_REQ=4, MULT_LAT=1, ideal 1-cycle multiplier model, res_ready=1 unless stated)
- REQ-029 SHALL check single request: req0 A=-3 B=5 at cycle T gives req_ready[0]=1 at T, mult_a=0xFD, and res_valid[0]=1 with res_p0=0xFFF1 at T+2.
- REQ-030 SHALL check all four requesters valid continuously after reset: grants occur in order 0,1,2,3, one per cycle, with results in the same order.
- REQ-031 SHALL check backpressure: res_ready[1]=0 for 10 cycles with req_valid[1] held; only one grant occurs, res_p1 is stable, and re-grant happens the cycle after the handshake.
- REQ-032 SHALL check extremes: A=-128 B=-128 gives 0x4000; A=127 B=-128 gives 0xC080; A=0 B=-1 gives 0x0000.
- REQ-033 SHALL check reset asserted the cycle after a grant: no res_valid appears afterwards, and the first post-reset grant goes to requester 0.
- REQ-034 SHALL check, with MULT_SHARE_FIXED_PRIO_EN defined and req0 and req2 always valid: grant order is 0,2,0,2,... as busy flags clear, and requester 2 is never granted while requester 0 is eligible.
